// File: rtl/ldtu_tx_pkg.sv
// ldtu_tx_pkg: shared types and constants for the LDTU output-word scheduler.
package ldtu_tx_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 32'hEAAA_AAAA;
    localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 32'hE000_0000;
    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_DATA = 3'd1,
        ST_CAL  = 3'd2,
        ST_TEST = 3'd3
    } tx_state_e;
endpackage

// File: rtl/ldtu_slot_timer.sv
// ldtu_slot_timer: divides the clock into WORD_CYCLES-long slots; flags the last cycle
// of each slot (boundary) and strobes the first cycle of the next one.
module ldtu_slot_timer #(
    parameter int WORD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic boundary,
    output logic strobe
);
    localparam int CW = $clog2(WORD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WORD_CYCLES - 1);
    logic [CW-1:0] slot_cnt;
    assign boundary = slot_cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            slot_cnt <= boundary ? '0 : slot_cnt + 1'b1;
            strobe   <= boundary;
        end
    end
endmodule

// File: rtl/ldtu_tx_scheduler.sv
// ldtu_tx_scheduler: picks SYNC/DATA/IDLE/TEST word per slot, pops the FIFO, tracks lock.
// LDTU_IDLE_SEQ_EN: when defined, IDLE words carry an 8-bit sequence count in [7:0].
module ldtu_tx_scheduler
    import ldtu_tx_pkg::*;
#(
    parameter int                WORD_CYCLES = 4,
    parameter int                HS_LOCK     = 3,
    parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              HANDSHAKE,
    input  logic              CALIBRATION_BUSY,
    input  logic              TEST_ENABLE,
    input  logic              FIFO_EMPTY,
    input  logic [WORD_W-1:0] FIFO_DATA,
    input  logic [WORD_W-1:0] ATU_WORD,
    output logic              FIFO_RD,
    output logic [WORD_W-1:0] TX_WORD,
    output logic              TX_STROBE,
    output logic [2:0]        STATE,
    output logic              SYNC_LOCKED
);
    localparam int LW = $clog2(HS_LOCK + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(HS_LOCK);
    logic boundary;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic locked_nxt;
    tx_state_e state, state_nxt;
    logic [WORD_W-1:0] idle_word, word_nxt;

    ldtu_slot_timer #(.WORD_CYCLES(WORD_CYCLES)) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .boundary (boundary),
        .strobe   (TX_STROBE)
    );

    // lock is evaluated first so the state choice sees this boundary's lock
    assign lock_nxt   = !HANDSHAKE ? '0 : (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + 1'b1;
    assign locked_nxt = lock_nxt == LOCK_MAX;

    always_comb begin
        state_nxt = CALIBRATION_BUSY ? ST_CAL : TEST_ENABLE ? ST_TEST : locked_nxt ? ST_DATA : ST_SYNC;
        word_nxt  = (state_nxt == ST_SYNC) ? SYNC_WORD :
                    (state_nxt == ST_TEST) ? ATU_WORD :
                    (state_nxt == ST_DATA && !FIFO_EMPTY) ? FIFO_DATA : idle_word;
    end

    assign FIFO_RD = boundary && state_nxt == ST_DATA && !FIFO_EMPTY;
    assign STATE   = state;

`ifdef LDTU_IDLE_SEQ_EN
    logic [7:0] seq;
    logic       launch_idle;
    assign launch_idle = state_nxt == ST_CAL || (state_nxt == ST_DATA && FIFO_EMPTY);
    assign idle_word   = IDLE_WORD | {{(WORD_W-8){1'b0}}, seq};
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            seq <= '0;
        else if (boundary && launch_idle)
            seq <= seq + 1'b1;
    end
`else
    assign idle_word = IDLE_WORD;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_SYNC;
            TX_WORD     <= SYNC_WORD;
            lock_cnt    <= '0;
            SYNC_LOCKED <= 1'b0;
        end else if (boundary) begin
            state       <= state_nxt;
            TX_WORD     <= word_nxt;
            lock_cnt    <= lock_nxt;
            SYNC_LOCKED <= locked_nxt;
        end
    end
endmodule

// File: tb/tb_ldtu_tx_scheduler.sv
// tb_ldtu_tx_scheduler: directed slot-by-slot checks of ldtu_tx_scheduler with a small FIFO model.
module tb_ldtu_tx_scheduler;
    localparam logic [31:0] SYNC = 32'hEAAA_AAAA;
    localparam logic [31:0] ATU  = 32'hA5A5_5A5A;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        HANDSHAKE = 1'b0;
    logic        CALIBRATION_BUSY = 1'b0;
    logic        TEST_ENABLE = 1'b0;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [31:0] ATU_WORD = '0;
    logic        FIFO_RD;
    logic [31:0] TX_WORD;
    logic        TX_STROBE;
    logic [2:0]  STATE;
    logic        SYNC_LOCKED;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] mem [16];
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [31:0] idle_last = 32'hE000_0000;
`ifdef LDTU_IDLE_SEQ_EN
    logic [7:0] seq = '0;
`endif

    ldtu_tx_scheduler dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .HANDSHAKE        (HANDSHAKE),
        .CALIBRATION_BUSY (CALIBRATION_BUSY),
        .TEST_ENABLE      (TEST_ENABLE),
        .FIFO_EMPTY       (FIFO_EMPTY),
        .FIFO_DATA        (FIFO_DATA),
        .ATU_WORD         (ATU_WORD),
        .FIFO_RD          (FIFO_RD),
        .TX_WORD          (TX_WORD),
        .TX_STROBE        (TX_STROBE),
        .STATE            (STATE),
        .SYNC_LOCKED      (SYNC_LOCKED)
    );

    always #5 CLK = ~CLK;

    // first-word-fall-through FIFO model
    assign FIFO_EMPTY = rd_cnt == wr_cnt;
    assign FIFO_DATA  = mem[rd_cnt[3:0]];
    always @(posedge CLK)
        if (FIFO_RD && rd_cnt != wr_cnt)
            rd_cnt <= rd_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_idle();
`ifdef LDTU_IDLE_SEQ_EN
        exp_idle = 32'hE000_0000 | {24'd0, seq};
        seq = seq + 8'd1;
`else
        exp_idle = 32'hE000_0000;
`endif
        idle_last = exp_idle;
    endfunction

    // called on the negedge of a slot's first cycle; returns there one slot later
    task automatic slot(input string tag, input logic rd, input logic [31:0] word,
                        input logic [2:0] st, input logic lk);
        @(negedge CLK);
        check({tag, "_strobe_mid"}, TX_STROBE, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check({tag, "_rd"}, FIFO_RD, rd);
        @(negedge CLK);
        check({tag, "_word"}, TX_WORD, word);
        check({tag, "_state"}, STATE, st);
        check({tag, "_lock"}, SYNC_LOCKED, lk);
        check({tag, "_strobe"}, TX_STROBE, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_word"}, TX_WORD, SYNC);
        check({tag, "_strobe"}, TX_STROBE, 1'b0);
        check({tag, "_rd"}, FIFO_RD, 1'b0);
        check({tag, "_state"}, STATE, 3'd0);
        check({tag, "_lock"}, SYNC_LOCKED, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (2) @(negedge CLK);
        check_reset("rst");
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) slot("sync", 1'b0, SYNC, 3'd0, 1'b0);

        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        wr_cnt = 2;
        HANDSHAKE = 1'b1;
        slot("train1", 1'b0, SYNC, 3'd0, 1'b0);
        slot("train2", 1'b0, SYNC, 3'd0, 1'b0);
        slot("lock", 1'b1, 32'h1111_1111, 3'd1, 1'b1);
        slot("pop2", 1'b1, 32'h2222_2222, 3'd1, 1'b1);
        slot("idle", 1'b0, exp_idle(), 3'd1, 1'b1);

        // calibration raised mid-slot with data waiting
        @(negedge CLK);
        CALIBRATION_BUSY = 1'b1;
        mem[2] = 32'h3333_3333;
        wr_cnt = 3;
        @(negedge CLK);
        check("cal_hold_word", TX_WORD, idle_last);
        @(negedge CLK);
        check("cal_rd", FIFO_RD, 1'b0);
        @(negedge CLK);
        check("cal_state", STATE, 3'd2);
        check("cal_word", TX_WORD, exp_idle());
        slot("cal2", 1'b0, exp_idle(), 3'd2, 1'b1);
        CALIBRATION_BUSY = 1'b0;
        slot("cal_exit", 1'b1, 32'h3333_3333, 3'd1, 1'b1);

        TEST_ENABLE = 1'b1;
        CALIBRATION_BUSY = 1'b1;
        ATU_WORD = ATU;
        mem[3] = 32'h4444_4444;
        wr_cnt = 4;
        slot("cal_wins", 1'b0, exp_idle(), 3'd2, 1'b1);
        CALIBRATION_BUSY = 1'b0;
        slot("test", 1'b0, ATU, 3'd3, 1'b1);
        slot("test2", 1'b0, ATU, 3'd3, 1'b1);
        TEST_ENABLE = 1'b0;
        slot("test_exit", 1'b1, 32'h4444_4444, 3'd1, 1'b1);
        slot("idle2", 1'b0, exp_idle(), 3'd1, 1'b1);

        HANDSHAKE = 1'b0;
        slot("hs_drop", 1'b0, SYNC, 3'd0, 1'b0);
        HANDSHAKE = 1'b1;
        slot("relock1", 1'b0, SYNC, 3'd0, 1'b0);
        slot("relock2", 1'b0, SYNC, 3'd0, 1'b0);
        slot("relock3", 1'b0, exp_idle(), 3'd1, 1'b1);
        check("pops", rd_cnt, 4);

        // reset pulse with slot_cnt == 2 while in DATA
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_reset("midrst");
`ifdef LDTU_IDLE_SEQ_EN
        seq = '0;
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge CLK);
            #1;
            if (TX_STROBE) lat = i;
        end
        check("strobe_latency", lat, 4);
        @(negedge CLK);
        check("post_rst_word", TX_WORD, SYNC);
        check("post_rst_state", STATE, 3'd0);
        check("post_rst_lock", SYNC_LOCKED, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
